// File: rtl/sc_gamectrl_pkg.sv
// Shared definitions for the Frogger game controller: state encoding and debug bus width.
package sc_gamectrl_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 4'd0,
    ST_START     = 4'd1,
    ST_PLAY      = 4'd2,
    ST_LOSELIFE  = 4'd3,
    ST_HOUSE     = 4'd4,
    ST_NEXTLEVEL = 4'd5,
    ST_WAIT      = 4'd6,
    ST_LOSEGAME  = 4'd7,
    ST_WINGAME   = 4'd8
  } state_e;

endpackage

// File: rtl/sc_counter_transition.sv
// Loadable down-counter with a zero flag; times the post-death and level-change freeze.
module sc_counter_transition #(
  parameter int WIDTH = 8
) (
  input  logic             i_clock,
  input  logic             i_resetN,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_loadValue,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  // Load has priority over decrement; the count parks at zero instead of wrapping.
  always_ff @(posedge i_clock or negedge i_resetN) begin
    if (!i_resetN) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadValue;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/sc_statemachine_gamectrl.sv
// Frogger game controller: sequences start/play/death/house/level/win/lose and owns
// the lives, level and house-occupancy counters plus the freeze timer.
module sc_statemachine_gamectrl
  import sc_gamectrl_pkg::*;
#(
  parameter  int LIVES       = 3,
  parameter  int LEVELS      = 4,
  parameter  int HOUSES      = 4,
  parameter  int WAIT_CYCLES = 25_000_000,
  localparam int LIFE_W      = $clog2(LIVES + 1),
  localparam int LEVEL_W     = (LEVELS > 1) ? $clog2(LEVELS) : 1,
  localparam int HOUSE_W     = $clog2(HOUSES)
) (
  input  logic               SC_STATEMACHINEGAMECTRL_CLOCK_50,
  input  logic               SC_STATEMACHINEGAMECTRL_RESET_InLow,
  input  logic               SC_STATEMACHINEGAMECTRL_startButton_InLow,
  input  logic               SC_STATEMACHINEGAMECTRL_Collision_InLow,
  input  logic               SC_STATEMACHINEGAMECTRL_HouseReached_InLow,
  input  logic [HOUSE_W-1:0] SC_STATEMACHINEGAMECTRL_HouseIndex_InBUS,
  output logic [LIFE_W-1:0]  SC_STATEMACHINEGAMECTRL_Lives_OutBUS,
  output logic [LEVEL_W-1:0] SC_STATEMACHINEGAMECTRL_Level_OutBUS,
  output logic [HOUSES-1:0]  SC_STATEMACHINEGAMECTRL_Houses_OutBUS,
  output logic               SC_STATEMACHINEGAMECTRL_ClearFrog_OutLow,
  output logic               SC_STATEMACHINEGAMECTRL_LoadLevel_OutLow,
  output logic               SC_STATEMACHINEGAMECTRL_Run_OutLow,
  output logic               SC_STATEMACHINEGAMECTRL_Win_OutHigh,
  output logic               SC_STATEMACHINEGAMECTRL_Lose_OutHigh,
  output logic [STATE_W-1:0] SC_STATEMACHINEGAMECTRL_State_OutBUS
);

  localparam int                   TIMER_W     = $clog2(WAIT_CYCLES);
  localparam int                   SEL_W       = 2 ** HOUSE_W;
  localparam logic [TIMER_W-1:0]   TIMER_LOAD  = TIMER_W'(WAIT_CYCLES - 1);
  localparam logic [LIFE_W-1:0]    LIVES_INIT  = LIFE_W'(LIVES);
  localparam logic [LEVEL_W-1:0]   LEVEL_LAST  = LEVEL_W'(LEVELS - 1);
  localparam logic [HOUSES-1:0]    HOUSES_FULL = '1;

  state_e              r_state;
  state_e              w_stateNext;
  logic                r_btnPrev;
  logic [LIFE_W-1:0]   r_lives;
  logic [LEVEL_W-1:0]  r_level;
  logic [HOUSES-1:0]   r_houses;
  logic [HOUSES-1:0]   r_pendSel;
  logic [HOUSES-1:0]   w_housesNext;
  logic [SEL_W-1:0]    w_sel;
  logic                w_startEvt;
  logic                w_idxValid;
  logic                w_doubleFill;
  logic                w_timerLoad;
  logic                w_timerDec;
  logic                w_timerZero;

  assign w_startEvt   = !SC_STATEMACHINEGAMECTRL_startButton_InLow && r_btnPrev;
  assign w_idxValid   = |w_sel[HOUSES-1:0];
  assign w_doubleFill = |(w_sel[HOUSES-1:0] & r_houses);
  assign w_housesNext = r_houses | r_pendSel;
  assign w_timerLoad  = (r_state != ST_WAIT) && (w_stateNext == ST_WAIT);
  assign w_timerDec   = (r_state == ST_WAIT);

  // One-hot decode of the house index; an out-of-range index decodes outside the bitmap.
  always_comb begin
    w_sel = '0;
    w_sel[SC_STATEMACHINEGAMECTRL_HouseIndex_InBUS] = 1'b1;
  end

  sc_counter_transition #(
    .WIDTH(TIMER_W)
  ) u_freezeTimer (
    .i_clock    (SC_STATEMACHINEGAMECTRL_CLOCK_50),
    .i_resetN   (SC_STATEMACHINEGAMECTRL_RESET_InLow),
    .i_load     (w_timerLoad),
    .i_loadValue(TIMER_LOAD),
    .i_dec      (w_timerDec),
    .o_zero     (w_timerZero)
  );

  // State register.
  always_ff @(posedge SC_STATEMACHINEGAMECTRL_CLOCK_50 or negedge SC_STATEMACHINEGAMECTRL_RESET_InLow) begin
    if (!SC_STATEMACHINEGAMECTRL_RESET_InLow) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state selection with collision taking priority over any house strobe.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE, ST_LOSEGAME, ST_WINGAME: begin
        if (w_startEvt) w_stateNext = ST_START;
      end
      ST_START: w_stateNext = ST_PLAY;
      ST_PLAY: begin
        if (!SC_STATEMACHINEGAMECTRL_Collision_InLow) begin
          w_stateNext = ST_LOSELIFE;
        end else if (!SC_STATEMACHINEGAMECTRL_HouseReached_InLow) begin
          if (!w_idxValid || w_doubleFill) w_stateNext = ST_LOSELIFE;
          else                             w_stateNext = ST_HOUSE;
        end
      end
      ST_LOSELIFE:  w_stateNext = (r_lives <= LIFE_W'(1)) ? ST_LOSEGAME : ST_WAIT;
      ST_HOUSE:     w_stateNext = (w_housesNext == HOUSES_FULL) ? ST_NEXTLEVEL : ST_PLAY;
      ST_NEXTLEVEL: w_stateNext = (r_level == LEVEL_LAST) ? ST_WINGAME : ST_WAIT;
      ST_WAIT: begin
        if (w_timerZero) w_stateNext = ST_PLAY;
      end
      default:      w_stateNext = ST_IDLE;
    endcase
  end

  // Moore output decode; strobes are active-low.
  always_comb begin
    SC_STATEMACHINEGAMECTRL_ClearFrog_OutLow = 1'b1;
    SC_STATEMACHINEGAMECTRL_LoadLevel_OutLow = 1'b1;
    SC_STATEMACHINEGAMECTRL_Run_OutLow       = 1'b1;
    SC_STATEMACHINEGAMECTRL_Win_OutHigh      = 1'b0;
    SC_STATEMACHINEGAMECTRL_Lose_OutHigh     = 1'b0;
    case (r_state)
      ST_START: begin
        SC_STATEMACHINEGAMECTRL_ClearFrog_OutLow = 1'b0;
        SC_STATEMACHINEGAMECTRL_LoadLevel_OutLow = 1'b0;
      end
      ST_PLAY:      SC_STATEMACHINEGAMECTRL_Run_OutLow       = 1'b0;
      ST_LOSELIFE:  SC_STATEMACHINEGAMECTRL_ClearFrog_OutLow = 1'b0;
      ST_HOUSE:     SC_STATEMACHINEGAMECTRL_ClearFrog_OutLow = 1'b0;
      ST_NEXTLEVEL: SC_STATEMACHINEGAMECTRL_LoadLevel_OutLow = (r_level == LEVEL_LAST);
      ST_LOSEGAME:  SC_STATEMACHINEGAMECTRL_Lose_OutHigh     = 1'b1;
      ST_WINGAME:   SC_STATEMACHINEGAMECTRL_Win_OutHigh      = 1'b1;
      default: ;
    endcase
  end

  // Button edge sampling and the game counters; each action state commits on its exit edge.
  always_ff @(posedge SC_STATEMACHINEGAMECTRL_CLOCK_50 or negedge SC_STATEMACHINEGAMECTRL_RESET_InLow) begin
    if (!SC_STATEMACHINEGAMECTRL_RESET_InLow) begin
      r_btnPrev <= 1'b1;
      r_lives   <= LIVES_INIT;
      r_level   <= '0;
      r_houses  <= '0;
      r_pendSel <= '0;
    end else begin
      r_btnPrev <= SC_STATEMACHINEGAMECTRL_startButton_InLow;
      case (r_state)
        ST_IDLE, ST_LOSEGAME, ST_WINGAME: begin
          if (w_startEvt) begin
            r_lives  <= LIVES_INIT;
            r_level  <= '0;
            r_houses <= '0;
          end
        end
        ST_PLAY:     r_pendSel <= w_sel[HOUSES-1:0];
        ST_LOSELIFE: begin
          if (r_lives != '0) r_lives <= r_lives - 1'b1;
        end
        ST_HOUSE:    r_houses <= w_housesNext;
        ST_NEXTLEVEL: begin
          r_houses <= '0;
          if (r_level != LEVEL_LAST) r_level <= r_level + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign SC_STATEMACHINEGAMECTRL_Lives_OutBUS  = r_lives;
  assign SC_STATEMACHINEGAMECTRL_Level_OutBUS  = r_level;
  assign SC_STATEMACHINEGAMECTRL_Houses_OutBUS = r_houses;
  assign SC_STATEMACHINEGAMECTRL_State_OutBUS  = r_state;

endmodule

// File: tb/tb_sc_statemachine_gamectrl.sv
// Directed scoreboard bench for the Frogger game controller with a 4-cycle freeze.
module tb_sc_statemachine_gamectrl;

  localparam int WAITC = 4;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_START     = 4'd1;
  localparam logic [3:0] S_PLAY      = 4'd2;
  localparam logic [3:0] S_LOSELIFE  = 4'd3;
  localparam logic [3:0] S_HOUSE     = 4'd4;
  localparam logic [3:0] S_NEXTLEVEL = 4'd5;
  localparam logic [3:0] S_WAIT      = 4'd6;
  localparam logic [3:0] S_LOSEGAME  = 4'd7;
  localparam logic [3:0] S_WINGAME   = 4'd8;

  typedef struct {
    string      tag;
    logic [3:0] st;
    logic [1:0] lv;
    logic [1:0] lvl;
    logic [3:0] hs;
    logic [4:0] fl;
  } expT;

  expT expQ[$];
  int  assertCount = 0;
  int  failCount   = 0;

  logic       clk = 1'b0;
  logic       rstN;
  logic       btnN;
  logic       collN;
  logic       hrN;
  logic [1:0] idx;
  logic [1:0] livesO;
  logic [1:0] levelO;
  logic [3:0] housesO;
  logic [3:0] stateO;
  logic       clearO;
  logic       loadO;
  logic       runO;
  logic       winO;
  logic       loseO;

  always #5 clk = ~clk;

  sc_statemachine_gamectrl #(
    .LIVES(3), .LEVELS(4), .HOUSES(4), .WAIT_CYCLES(WAITC)
  ) dut (
    .SC_STATEMACHINEGAMECTRL_CLOCK_50          (clk),
    .SC_STATEMACHINEGAMECTRL_RESET_InLow       (rstN),
    .SC_STATEMACHINEGAMECTRL_startButton_InLow (btnN),
    .SC_STATEMACHINEGAMECTRL_Collision_InLow   (collN),
    .SC_STATEMACHINEGAMECTRL_HouseReached_InLow(hrN),
    .SC_STATEMACHINEGAMECTRL_HouseIndex_InBUS  (idx),
    .SC_STATEMACHINEGAMECTRL_Lives_OutBUS      (livesO),
    .SC_STATEMACHINEGAMECTRL_Level_OutBUS      (levelO),
    .SC_STATEMACHINEGAMECTRL_Houses_OutBUS     (housesO),
    .SC_STATEMACHINEGAMECTRL_ClearFrog_OutLow  (clearO),
    .SC_STATEMACHINEGAMECTRL_LoadLevel_OutLow  (loadO),
    .SC_STATEMACHINEGAMECTRL_Run_OutLow        (runO),
    .SC_STATEMACHINEGAMECTRL_Win_OutHigh       (winO),
    .SC_STATEMACHINEGAMECTRL_Lose_OutHigh      (loseO),
    .SC_STATEMACHINEGAMECTRL_State_OutBUS      (stateO)
  );

  // Expected strobe/indicator pattern {clear, load, run, win, lose} for a given state and level.
  function automatic logic [4:0] flagsFor(logic [3:0] st, logic [1:0] lvl);
    logic clr, ld, rn, wn, ls;
    clr = !((st == S_START) || (st == S_LOSELIFE) || (st == S_HOUSE));
    ld  = !((st == S_START) || ((st == S_NEXTLEVEL) && (lvl != 2'd3)));
    rn  = (st != S_PLAY);
    wn  = (st == S_WINGAME);
    ls  = (st == S_LOSEGAME);
    return {clr, ld, rn, wn, ls};
  endfunction

  task automatic cmp(string tag, string field, logic [7:0] obs, logic [7:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
    end
  endtask

  task automatic pushExp(string tag, logic [3:0] st, logic [1:0] lv, logic [1:0] lvl, logic [3:0] hs);
    expT e;
    e.tag = tag;
    e.st  = st;
    e.lv  = lv;
    e.lvl = lvl;
    e.hs  = hs;
    e.fl  = flagsFor(st, lvl);
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(logic btn, logic coll, logic hr, logic [1:0] ix);
    btnN  = btn;
    collN = coll;
    hrN   = hr;
    idx   = ix;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput();
    expT e;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      cmp(e.tag, "state",  {4'd0, stateO}, {4'd0, e.st});
      cmp(e.tag, "lives",  {6'd0, livesO}, {6'd0, e.lv});
      cmp(e.tag, "level",  {6'd0, levelO}, {6'd0, e.lvl});
      cmp(e.tag, "houses", {4'd0, housesO}, {4'd0, e.hs});
      cmp(e.tag, "flags",  {3'd0, clearO, loadO, runO, winO, loseO}, {3'd0, e.fl});
    end
  endtask

  task automatic cyc(string tag, logic btn, logic coll, logic hr, logic [1:0] ix,
                     logic [3:0] st, logic [1:0] lv, logic [1:0] lvl, logic [3:0] hs);
    pushExp(tag, st, lv, lvl, hs);
    applyStimulus(btn, coll, hr, ix);
    checkOutput();
  endtask

  // A fatal event in PLAY, then either game over or the full freeze and return to play.
  task automatic die(string tag, logic coll, logic hr, logic [1:0] ix, int livesBefore,
                     logic [1:0] lvl, logic [3:0] hs, logic cw);
    logic [1:0] lvAfter;
    lvAfter = 2'(livesBefore - 1);
    cyc({tag, ".hit"}, 1'b1, coll, hr, ix, S_LOSELIFE, 2'(livesBefore), lvl, hs);
    if (livesBefore == 1) begin
      cyc({tag, ".over"}, 1'b1, 1'b1, 1'b1, 2'd0, S_LOSEGAME, 2'd0, lvl, hs);
    end else begin
      for (int i = 0; i < WAITC; i++)
        cyc({tag, ".wait"}, 1'b1, cw, 1'b1, 2'd0, S_WAIT, lvAfter, lvl, hs);
      cyc({tag, ".play"}, 1'b1, cw, 1'b1, 2'd0, S_PLAY, lvAfter, lvl, hs);
    end
  endtask

  // One house strobe; completing the bitmap walks through NEXTLEVEL into WAIT or WINGAME.
  task automatic fillHouse(string tag, logic [1:0] ix, logic [3:0] hsBefore, logic [1:0] lv,
                           logic [1:0] lvl, logic btn);
    logic [3:0] hsAfter;
    hsAfter = hsBefore | (4'b0001 << ix);
    cyc({tag, ".strobe"}, btn, 1'b1, 1'b0, ix, S_HOUSE, lv, lvl, hsBefore);
    if (hsAfter != 4'hF) begin
      cyc({tag, ".set"}, btn, 1'b1, 1'b1, 2'd0, S_PLAY, lv, lvl, hsAfter);
    end else begin
      cyc({tag, ".full"}, btn, 1'b1, 1'b1, 2'd0, S_NEXTLEVEL, lv, lvl, 4'hF);
      if (lvl == 2'd3) begin
        cyc({tag, ".win"}, btn, 1'b1, 1'b1, 2'd0, S_WINGAME, lv, lvl, 4'h0);
      end else begin
        for (int i = 0; i < WAITC; i++)
          cyc({tag, ".wait"}, btn, 1'b1, 1'b1, 2'd0, S_WAIT, lv, 2'(lvl + 2'd1), 4'h0);
        cyc({tag, ".play"}, btn, 1'b1, 1'b1, 2'd0, S_PLAY, lv, 2'(lvl + 2'd1), 4'h0);
      end
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] hs;
    rstN  = 1'b0;
    btnN  = 1'b1;
    collN = 1'b1;
    hrN   = 1'b1;
    idx   = 2'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    pushExp("reset", S_IDLE, 2'd3, 2'd0, 4'h0);
    checkOutput();
    rstN = 1'b1;
    cyc("idle", 1'b1, 1'b1, 1'b1, 2'd0, S_IDLE, 2'd3, 2'd0, 4'h0);

    // Start, with the button held through PLAY
    cyc("start",     1'b0, 1'b1, 1'b1, 2'd0, S_START, 2'd3, 2'd0, 4'h0);
    cyc("startPlay", 1'b0, 1'b1, 1'b1, 2'd0, S_PLAY,  2'd3, 2'd0, 4'h0);
    cyc("held",      1'b0, 1'b1, 1'b1, 2'd0, S_PLAY,  2'd3, 2'd0, 4'h0);
    cyc("release",   1'b1, 1'b1, 1'b1, 2'd0, S_PLAY,  2'd3, 2'd0, 4'h0);

    // Three deaths; the second one has collisions during the freeze that must be ignored
    die("death1", 1'b0, 1'b1, 2'd0, 3, 2'd0, 4'h0, 1'b1);
    die("death2", 1'b0, 1'b1, 2'd0, 2, 2'd0, 4'h0, 1'b0);
    die("death3", 1'b0, 1'b1, 2'd0, 1, 2'd0, 4'h0, 1'b1);
    cyc("loseHold", 1'b1, 1'b1, 1'b1, 2'd0, S_LOSEGAME, 2'd0, 2'd0, 4'h0);

    // Restart from LOSEGAME reloads the counters
    cyc("restart",     1'b0, 1'b1, 1'b1, 2'd0, S_START, 2'd3, 2'd0, 4'h0);
    cyc("restartPlay", 1'b1, 1'b1, 1'b1, 2'd0, S_PLAY,  2'd3, 2'd0, 4'h0);

    // Level 0: fill all houses in order
    hs = 4'h0;
    for (int h = 0; h < 4; h++) begin
      fillHouse("lvl0", 2'(h), hs, 2'd3, 2'd0, 1'b1);
      hs = hs | (4'b0001 << h);
    end

    // Level 1: double fill and simultaneous collision+house both cost a life
    fillHouse("lvl1", 2'd2, 4'h0, 2'd3, 2'd1, 1'b1);
    die("double", 1'b1, 1'b0, 2'd2, 3, 2'd1, 4'h4, 1'b1);
    die("both",   1'b0, 1'b0, 2'd1, 2, 2'd1, 4'h4, 1'b1);
    fillHouse("lvl1", 2'd0, 4'h4, 2'd1, 2'd1, 1'b1);
    fillHouse("lvl1", 2'd1, 4'h5, 2'd1, 2'd1, 1'b1);
    fillHouse("lvl1", 2'd3, 4'h7, 2'd1, 2'd1, 1'b1);

    // Level 2
    hs = 4'h0;
    for (int h = 0; h < 4; h++) begin
      fillHouse("lvl2", 2'(h), hs, 2'd1, 2'd2, 1'b1);
      hs = hs | (4'b0001 << h);
    end

    // Level 3: button pressed during the final strobe and held into WINGAME
    hs = 4'h0;
    for (int h = 0; h < 3; h++) begin
      fillHouse("lvl3", 2'(h), hs, 2'd1, 2'd3, 1'b1);
      hs = hs | (4'b0001 << h);
    end
    fillHouse("lvl3", 2'd3, 4'h7, 2'd1, 2'd3, 1'b0);
    cyc("winHeld",    1'b0, 1'b1, 1'b1, 2'd0, S_WINGAME, 2'd1, 2'd3, 4'h0);
    cyc("winHeld",    1'b0, 1'b1, 1'b1, 2'd0, S_WINGAME, 2'd1, 2'd3, 4'h0);
    cyc("winRelease", 1'b1, 1'b1, 1'b1, 2'd0, S_WINGAME, 2'd1, 2'd3, 4'h0);
    cyc("winRestart", 1'b0, 1'b1, 1'b1, 2'd0, S_START,   2'd3, 2'd0, 4'h0);
    cyc("winPlay",    1'b1, 1'b1, 1'b1, 2'd0, S_PLAY,    2'd3, 2'd0, 4'h0);

    // Reset pulsed in the middle of a freeze
    cyc("midHit",  1'b1, 1'b0, 1'b1, 2'd0, S_LOSELIFE, 2'd3, 2'd0, 4'h0);
    cyc("midWait", 1'b1, 1'b1, 1'b1, 2'd0, S_WAIT,     2'd2, 2'd0, 4'h0);
    cyc("midWait", 1'b1, 1'b1, 1'b1, 2'd0, S_WAIT,     2'd2, 2'd0, 4'h0);
    #3;
    rstN = 1'b0;
    #1;
    pushExp("midReset", S_IDLE, 2'd3, 2'd0, 4'h0);
    checkOutput();
    @(posedge clk);
    #1;
    rstN = 1'b1;
    cyc("postReset",     1'b1, 1'b1, 1'b1, 2'd0, S_IDLE,  2'd3, 2'd0, 4'h0);
    cyc("postStart",     1'b0, 1'b1, 1'b1, 2'd0, S_START, 2'd3, 2'd0, 4'h0);
    cyc("postStartPlay", 1'b1, 1'b1, 1'b1, 2'd0, S_PLAY,  2'd3, 2'd0, 4'h0);
    die("postDeath", 1'b0, 1'b1, 2'd0, 3, 2'd0, 4'h0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
